// File: rtl/encryption_full.sv
// encryption_full: fully pipelined AES-128 encryption datapath.
// It accepts one plaintext block every cycle and produces each ciphertext block
// 10 cycles after its plaintext is sampled. All eleven round keys come in at once
// on the live key bus. The key is not pipelined, so the key must not change while
// any block is in the pipeline.
module encryption_full (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [1407:0] key,
    input  logic [127:0]  data,
    output logic [127:0]  cipherData
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] stage [1:10];

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The state is column-major, so byte index = 4*col + row. Byte 0 is the most
    // significant byte. ShiftRows rotates row r left by r, which means
    // out[row r][col c] = in[row r][col (c+r)%4].
    function automatic logic [127:0] sub_shift(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127 - 8 * (4 * c + r) -: 8] = sbox(x[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127 - 32 * c -: 8];
            a1 = x[119 - 32 * c -: 8];
            a2 = x[111 - 32 * c -: 8];
            a3 = x[103 - 32 * c -: 8];
            y[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            y[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            y[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            y[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return y;
    endfunction

    function automatic logic [127:0] round_key(input logic [1407:0] k, input int r);
        return k[1407 - 128 * r -: 128];
    endfunction

    function automatic logic [127:0] full_round(input logic [127:0] x, input logic [127:0] k);
        return mix_columns(sub_shift(x)) ^ k;
    endfunction

    // Ten-stage round pipeline. Stage 1 also performs the initial AddRoundKey,
    // and stage 10 is the final round, which has no MixColumns.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 1; i <= 10; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[1] <= full_round(data ^ round_key(key, 0), round_key(key, 1));
            for (int r = 2; r <= 9; r++) begin
                stage[r] <= full_round(stage[r - 1], round_key(key, r));
            end
            stage[10] <= sub_shift(stage[9]) ^ round_key(key, 10);
        end
    end

    assign cipherData = stage[10];

endmodule

// File: tb/tb_encryption_full.sv
// Directed bench for encryption_full. It uses known-answer vectors, latency and
// throughput checks, and reset behaviour.
module tb_encryption_full;

    logic          tb_clk;
    logic          n_rst;
    logic [1407:0] key;
    logic [127:0]  data;
    logic [127:0]  cipherData;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1407:0] KEY_A = {
        128'h5468617473206D79204B756E67204675,
        128'hE232FCF191129188B159E4E6D679A293,
        128'h56082007C71AB18F76435569A03AF7FA,
        128'hD2600DE7157ABC686339E901C3031EFB,
        128'hA11202C9B468BEA1D75157A01452495B,
        128'hB1293B3305418592D210D232C6429B69,
        128'hBD3DC287B87C47156A6C9527AC2E0E4E,
        128'hCC96ED1674EAAA031E863F24B2A8316A,
        128'h8E51EF21FABB4522E43D7A0656954B6C,
        128'hBFE2BF904559FAB2A16480B4F7F1CBD8,
        128'h28FDDEF86DA4244ACCC0A4FE3B316F26
    };
    localparam logic [127:0] PT_A = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CT_A = 128'h29C3505F571420F6402299B31A02D73A;

    localparam logic [1407:0] KEY_B = {
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] PT_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    encryption_full dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .key        (key),
        .data       (data),
        .cipherData (cipherData)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs !== exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h must differ from %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random data on the inputs.
        key   = KEY_A;
        data  = {$urandom, $urandom, $urandom, $urandom};
        n_rst = 1'b1;
        tick(1);
        data  = {$urandom, $urandom, $urandom, $urandom};
        tick(1);
        check_eq("reset_out", cipherData, 128'h0);
        for (int i = 1; i <= 10; i++) begin
            check_eq($sformatf("reset_stage%0d", i), dut.stage[i], 128'h0);
        end

        // Fill the pipeline with encryptions of zero, then check the latency of vector A.
        n_rst = 1'b0;
        data  = 128'h0;
        tick(12);
        data = PT_A;
        for (int e = 0; e <= 8; e++) begin
            tick(1);
            check_ne($sformatf("lat_a_edge%0d", e), cipherData, CT_A);
        end
        tick(1);
        check_eq("vec_a", cipherData, CT_A);
        for (int h = 0; h < 3; h++) begin
            tick(1);
            check_eq($sformatf("vec_a_hold%0d", h), cipherData, CT_A);
        end

        // Throughput: A, A with its last byte flipped, A on consecutive edges.
        data = 128'h0;
        tick(10);
        data = PT_A;
        tick(1);
        data = PT_A ^ 128'hff;
        tick(1);
        data = PT_A;
        tick(1);
        data = 128'h0;
        tick(6);
        check_ne("tput_pre", cipherData, CT_A);
        tick(1);
        check_eq("tput_first", cipherData, CT_A);
        tick(1);
        check_ne("tput_flipped", cipherData, CT_A);
        tick(1);
        check_eq("tput_third", cipherData, CT_A);
        tick(1);
        check_ne("tput_after", cipherData, CT_A);

        // Reset while blocks are in flight. Reset is asserted at the 5th edge of holding A.
        data = PT_A;
        tick(4);
        n_rst = 1'b1;
        tick(1);
        check_eq("midrst_0", cipherData, 128'h0);
        tick(1);
        check_eq("midrst_1", cipherData, 128'h0);
        n_rst = 1'b0;
        tick(9);
        check_ne("midrst_early", cipherData, CT_A);
        tick(1);
        check_eq("midrst_result", cipherData, CT_A);

        // Vector B (FIPS-197 C.1).
        key  = KEY_B;
        data = PT_B;
        tick(10);
        check_eq("vec_b", cipherData, CT_B);
        tick(2);
        check_eq("vec_b_hold", cipherData, CT_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/encryption_full.md
# encryption_full

Fully pipelined AES-128 encryption datapath (FIPS-197) that takes a pre-expanded key schedule and one 128-bit plaintext block per cycle. It sits behind the key-expansion block, which supplies all eleven round keys at once, and produces one ciphertext block per cycle after a fixed 10-cycle latency. There is no handshake: the block samples `data` on every clock edge.

## Interface
- No parameters. Widths are fixed by AES-128.
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous, active-high (asserted when 1).
- key  in  1408  expanded key schedule, 11 round keys of 128 bits each. rk0 = key[1407:1280], rk1 = key[1279:1152], … rk10 = key[127:0].
- data  in  128  plaintext block, sampled every cycle.
- cipherData  out  128  ciphertext block, registered.

## Operation
- Byte order follows FIPS-197: state byte 0 = bits [127:120], byte 15 = [7:0], filled column-major (bytes 0–3 form column 0).
- The pipeline has 10 registered stages, s1 through s10.
  - s1 <= Round(data ^ rk0, rk1)
  - s_r <= Round(s_{r-1}, rk_r) for r = 2..9
  - s10 <= AddRoundKey(ShiftRows(SubBytes(s9)), rk10), with no MixColumns in the last stage
- Round(x, k) = AddRoundKey(MixColumns(ShiftRows(SubBytes(x))), k).
- SubBytes uses the standard AES S-box on all 16 bytes in every stage.
  - The S-box is one shared function, either a 256-entry table or the GF(2^8) inverse plus affine transform.
  - It is instantiated combinationally per byte.
- ShiftRows rotates row i left by i bytes.
- MixColumns uses the standard matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), reduction polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- cipherData = s10.
- The key is not pipelined. Each stage uses the live `key` bus, so `key` must stay stable while any block is in flight. Results for blocks in flight during a key change are undefined.
- No decryption, no key expansion, no valid flag. Downstream logic tracks latency.

## Timing
- Reset: while n_rst = 1 at a rising edge, all stage registers clear to 0 and cipherData = 0. Reset takes priority over data flow.
- Latency: `data` sampled at edge N appears on cipherData after edge N+9 and is valid through edge N+10. That is 10 register stages, with the output valid in the cycle following the 10th edge.
- Throughput: one block per cycle. Back-to-back distinct blocks emerge in order on consecutive cycles.
- Reset mid-operation flushes all in-flight blocks; they are never output.
  - After reset deasserts, cipherData shows a pipeline fill of Round-chain values derived from whatever `data` was sampled.
  - The first meaningful result appears 10 edges after the first post-reset sample.
- `data` held constant: cipherData settles to its ciphertext 10 edges later and holds it.

## Test plan
- Reset: assert n_rst = 1 for 2 edges with random prior data -> cipherData = 0 and every stage register = 0.
- Vector A: rk0 = 5468617473206D79204B756E67204675 … rk10 = 28FDDEF86DA4244ACCC0A4FE3B316F26 (full 1408-bit schedule), data = 54776F204F6E65204E696E652054776F -> cipherData = 29C3505F571420F6402299B31A02D73A exactly 10 edges after sampling, and held while inputs are held.
- Vector B (FIPS-197 C.1): schedule from key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5), data = 00112233445566778899aabbccddeeff -> cipherData = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Throughput: with the Vector A key, drive block A, then block A with its last byte flipped, then block A again on consecutive cycles -> three outputs on consecutive cycles, the first and third equal to 29C3505F….
- Reset mid-flight: load Vector A, assert reset at edge 5 -> cipherData = 0 during reset; after release with data held, the correct ciphertext appears 10 edges later.
- Latency check: confirm cipherData does not equal the expected value at edge N+8 for a freshly changed input, and equals it after edge N+9.
